sync_bank: RTL and testbench
============================

# sync_bank

Multi-channel single-bit input synchronizer with per-channel glitch filter, edge detection and sticky event flags. Successor to the plain flip-flop synchronizer: each of WIDTH asynchronous inputs passes through a STAGES-deep synchronizer, then a stability filter, before driving a clean level output plus one-cycle rise/fall pulses. Sits at the boundary between off-chip or foreign-domain status lines (buttons, interrupts, ready flags) and `clk`-domain control logic.

## Interface
- WIDTH, 8: number of independent channels (≥1).
- STAGES, 2: synchronizer flops per channel (≥2; <2 is an elaboration error).
- FILTER, 4: consecutive cycles a synchronized value must differ from `sync_out` before `sync_out` follows. 0 = no filtering, same behaviour as 1.
- RESET_VAL, '0: WIDTH-bit reset value for synchronizer flops and `sync_out`.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-low.
- async_in  in  WIDTH  asynchronous inputs, one per channel.
- sync_out  out  WIDTH  filtered, synchronized level.
- rise  out  WIDTH  one-cycle pulse when `sync_out[i]` goes 0→1.
- fall  out  WIDTH  one-cycle pulse when `sync_out[i]` goes 1→0.
- event_pending  out  WIDTH  sticky: set on any rise/fall of channel i.
- event_clr  in  WIDTH  per-channel clear of `event_pending`.

## Operation
- Per channel i, fully independent; no cross-channel logic.
- Synchronizer: shift register `pipe[i][0..STAGES-1]`, `pipe[0]` samples `async_in[i]`; `raw[i] = pipe[i][STAGES-1]`. No logic between synchronizer flops.
- Filter counter `cnt[i]`, width $clog2(max(FILTER,1)+1):
  - `raw == sync_out`: `cnt <= 0`.
  - `raw != sync_out` and `cnt < max(FILTER,1)-1`: `cnt <= cnt+1`.
  - `raw != sync_out` and `cnt == max(FILTER,1)-1`: `sync_out <= raw`, `cnt <= 0`.
- Glitch rejection: any return of `raw` to `sync_out` before terminal count resets `cnt`; no output change, no pulse.
- rise/fall registered, asserted in the same cycle `sync_out` takes its new value, deasserted next cycle unless another transition occurs (impossible for FILTER≥2).
- event_pending: `pending <= (pending & ~event_clr) | rise | fall`. Set and clear in the same cycle: set wins.
- Reset (reset==0 at a clk edge): all `pipe` bits and `sync_out` to RESET_VAL[i], `cnt` 0, `rise`/`fall`/`event_pending` 0. Reset mid-filter discards the pending count; no pulse emitted for the aborted transition.
- After reset release with `async_in == RESET_VAL`, no pulses occur.

## Timing
- Edge 1 = first clk edge capturing a new `async_in` value in `pipe[0]`.
- `raw` shows the new value after edge STAGES.
- `sync_out`, `rise`/`fall` update at edge STAGES + max(FILTER,1). Defaults (2,4): edge 6.
- `event_pending` sets one edge after the rise/fall pulse; `event_clr` takes effect at the next edge.
- Minimum accepted pulse width on `raw`: max(FILTER,1) cycles; shorter is rejected.
- Throughput: one accepted transition per max(FILTER,1) cycles per channel.
- All outputs registered; no combinational path input→output.

## Test plan
- Reset: WIDTH=4, STAGES=2, FILTER=3, RESET_VAL=0, `async_in=4'hF` during 3 reset cycles → all outputs 0; after release `sync_out=4'hF` and `rise=4'hF` (1 cycle) at edge 5, `event_pending=4'hF` at edge 6.
- Glitch boundary: ch0 `async_in` high for exactly 2 cycles → no change on `sync_out[0]`, no `rise`; high for exactly 3 cycles → `sync_out[0]` 1 at edge 5, `rise[0]` pulse, then `fall[0]` 3 cycles later.
- Simultaneous channels: ch1 0→1 and ch2 1→0 on same cycle → `rise=4'b0010`, `fall=4'b0100` in the same cycle; ch0/ch3 unaffected.
- Pending set vs. clear: `event_clr[1]=1` in the cycle `rise[1]` pulses → `event_pending[1]` stays 1; `event_clr[1]=1` alone next cycle → 0 one edge later.
- Reset mid-filter: ch0 toggles, reset asserted at edge 4 → no pulse, outputs at RESET_VAL; after release behaves as fresh reset.
- FILTER=0, STAGES=3: single step → `sync_out` updates at edge 4; 1-cycle `async_in` pulse (held across an edge) propagates.

Source files
------------

// File: rtl/sync_bank.sv
// sync_bank: per-channel input synchronizer with stability filter,
// registered rise/fall pulses and sticky event flags.
module sync_bank #(
   parameter int               WIDTH     = 8,
   parameter int               STAGES    = 2,
   parameter int               FILTER    = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] event_pending,
   input  logic [WIDTH-1:0] event_clr
);

   localparam int FM = (FILTER < 1) ? 1 : FILTER;
   localparam int CW = $clog2(FM + 1);
   localparam logic [CW-1:0] TERM = CW'(FM - 1);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_bank: STAGES must be at least 2");
   end

   if (WIDTH < 1) begin : g_bad_width
      $error("sync_bank: WIDTH must be at least 1");
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      logic [STAGES-1:0] pipe;
      logic              raw;
      logic [CW-1:0]     cnt;
      logic [CW-1:0]     cnt_nxt;
      logic              level;
      logic              rise_q;
      logic              fall_q;
      logic              pend_q;
      logic              diff;
      logic              hit;

      // Plain shift chain: nothing may sit between these flops.
      always_ff @(posedge clk) begin
         if (!reset) begin
            pipe <= {STAGES{RESET_VAL[i]}};
         end else begin
            pipe <= {pipe[STAGES-2:0], async_in[i]};
         end
      end

      assign raw  = pipe[STAGES-1];
      assign diff = raw ^ level;
      assign hit  = diff && (cnt == TERM);

      always_comb begin
         cnt_nxt = '0;
         if (diff && !hit) begin
            cnt_nxt = cnt + CW'(1);
         end
      end

      // Any return of raw to the current level before terminal
      // count clears cnt, so short glitches never reach the output.
      always_ff @(posedge clk) begin
         if (!reset) begin
            cnt    <= '0;
            level  <= RESET_VAL[i];
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            pend_q <= 1'b0;
         end else begin
            cnt    <= cnt_nxt;
            if (hit) begin
               level <= raw;
            end
            rise_q <= hit & raw;
            fall_q <= hit & ~raw;
            pend_q <= (pend_q & ~event_clr[i]) | rise_q | fall_q;
         end
      end

      assign sync_out[i]      = level;
      assign rise[i]          = rise_q;
      assign fall[i]          = fall_q;
      assign event_pending[i] = pend_q;
   end

endmodule

// File: tb/tb_sync_bank.sv
// tb_sync_bank: directed checks of sync_bank in a filtered
// (STAGES=2, FILTER=3) and an unfiltered (STAGES=3, FILTER=0) build.
module tb_sync_bank;

   logic       clk;
   logic       reset;
   logic [3:0] a_in, a_clr, a_out, a_rise, a_fall, a_pend;
   logic [1:0] b_in, b_clr, b_out, b_rise, b_fall, b_pend;

   int n_chk;
   int n_fail;

   sync_bank #(
      .WIDTH(4), .STAGES(2), .FILTER(3), .RESET_VAL(4'h0)
   ) u_a (
      .clk(clk), .reset(reset), .async_in(a_in),
      .sync_out(a_out), .rise(a_rise), .fall(a_fall),
      .event_pending(a_pend), .event_clr(a_clr)
   );

   sync_bank #(
      .WIDTH(2), .STAGES(3), .FILTER(0), .RESET_VAL(2'b01)
   ) u_b (
      .clk(clk), .reset(reset), .async_in(b_in),
      .sync_out(b_out), .rise(b_rise), .fall(b_fall),
      .event_pending(b_pend), .event_clr(b_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b0;
      a_in   = 4'hF;
      a_clr  = 4'h0;
      b_in   = 2'b01;
      b_clr  = 2'b00;

      // Reset with inputs high
      repeat (3) tick();
      chk("rst_out", a_out, 4'h0);
      chk("rst_rise", a_rise, 4'h0);
      chk("rst_fall", a_fall, 4'h0);
      chk("rst_pend", a_pend, 4'h0);
      chk("rst_b_out", {2'b00, b_out}, 4'h1);
      reset = 1'b1;
      repeat (4) tick();
      chk("rel_e4_out", a_out, 4'h0);
      tick();
      chk("rel_e5_out", a_out, 4'hF);
      chk("rel_e5_rise", a_rise, 4'hF);
      chk("rel_e5_pend", a_pend, 4'h0);
      chk("rel_b_rise", {2'b00, b_rise}, 4'h0);
      tick();
      chk("rel_e6_rise", a_rise, 4'h0);
      chk("rel_e6_pend", a_pend, 4'hF);
      chk("rel_b_fall", {2'b00, b_fall}, 4'h0);
      a_clr = 4'hF;
      tick();
      a_clr = 4'h0;
      chk("clr_all", a_pend, 4'h0);

      // Bring ch0/1/3 low, ch2 stays high
      a_in = 4'b0100;
      repeat (5) tick();
      chk("dn_out", a_out, 4'b0100);
      chk("dn_fall", a_fall, 4'b1011);
      tick();
      chk("dn_fall_end", a_fall, 4'h0);
      chk("dn_pend", a_pend, 4'b1011);
      a_clr = 4'hF;
      tick();
      a_clr = 4'h0;
      chk("dn_clr", a_pend, 4'h0);

      // Two-cycle glitch on ch0 is rejected
      a_in = 4'b0101;
      repeat (2) tick();
      a_in = 4'b0100;
      for (int k = 0; k < 6; k++) begin
         chk("gl2_rise", a_rise, 4'h0);
         chk("gl2_out", a_out, 4'b0100);
         tick();
      end
      chk("gl2_pend", a_pend, 4'h0);

      // Three-cycle pulse on ch0 is accepted
      a_in = 4'b0101;
      repeat (3) tick();
      a_in = 4'b0100;
      tick();
      chk("gl3_e4_out", a_out, 4'b0100);
      tick();
      chk("gl3_e5_out", a_out, 4'b0101);
      chk("gl3_e5_rise", a_rise, 4'b0001);
      tick();
      chk("gl3_e6_rise", a_rise, 4'h0);
      tick();
      chk("gl3_e7_out", a_out, 4'b0101);
      tick();
      chk("gl3_e8_out", a_out, 4'b0100);
      chk("gl3_e8_fall", a_fall, 4'b0001);
      tick();
      chk("gl3_e9_fall", a_fall, 4'h0);
      chk("gl3_pend", a_pend, 4'b0001);
      a_clr = 4'hF;
      tick();
      a_clr = 4'h0;

      // ch1 rises and ch2 falls together; set beats clear on ch1
      a_in = 4'b0010;
      repeat (4) tick();
      chk("sim_e4_out", a_out, 4'b0100);
      tick();
      chk("sim_rise", a_rise, 4'b0010);
      chk("sim_fall", a_fall, 4'b0100);
      chk("sim_out", a_out, 4'b0010);
      a_clr = 4'b0010;
      tick();
      chk("set_wins", a_pend, 4'b0110);
      tick();
      a_clr = 4'h0;
      chk("clr_ch1", a_pend, 4'b0100);

      // Reset lands while ch0 is still filtering
      a_in = 4'b0011;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("mid_out", a_out, 4'h0);
      chk("mid_rise", a_rise, 4'h0);
      chk("mid_pend", a_pend, 4'h0);
      tick();
      reset = 1'b1;
      repeat (4) tick();
      chk("mid_e4_rise", a_rise, 4'h0);
      tick();
      chk("mid_e5_out", a_out, 4'b0011);
      chk("mid_e5_rise", a_rise, 4'b0011);
      tick();
      chk("mid_e6_pend", a_pend, 4'b0011);
      chk("mid_b_out", {2'b00, b_out}, 4'h1);

      // Unfiltered build: step then a one-cycle pulse
      b_in = 2'b10;
      repeat (3) tick();
      chk("b_e3_out", {2'b00, b_out}, 4'h1);
      tick();
      chk("b_e4_out", {2'b00, b_out}, 4'h2);
      chk("b_e4_rise", {2'b00, b_rise}, 4'h2);
      chk("b_e4_fall", {2'b00, b_fall}, 4'h1);
      tick();
      chk("b_e5_rise", {2'b00, b_rise}, 4'h0);
      chk("b_e5_pend", {2'b00, b_pend}, 4'h3);
      b_in = 2'b00;
      tick();
      b_in = 2'b10;
      repeat (2) tick();
      chk("bp_e3_out", {2'b00, b_out}, 4'h2);
      tick();
      chk("bp_e4_out", {2'b00, b_out}, 4'h0);
      chk("bp_e4_fall", {2'b00, b_fall}, 4'h2);
      tick();
      chk("bp_e5_out", {2'b00, b_out}, 4'h2);
      chk("bp_e5_rise", {2'b00, b_rise}, 4'h2);
      chk("bp_e5_fall", {2'b00, b_fall}, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
